// File: rtl/pc_stack_seq.sv
// pc_stack_seq: parametrised program-counter sequencer with load, call/return,
// signed relative branch and increment, plus wrap / error / stack status flags.
// Optional feature macro: PC_RET_STACK_EN builds the return-address stack.
// Without it, call_pc acts as a plain load of call_tgt, ret_pc holds the PC, and
// the stk_* outputs are tied to 0.
module pc_stack_seq #(
    parameter int PC_W      = 6,
    parameter int STEP      = 1,
    parameter int STK_DEPTH = 4,
    parameter int RST_VAL   = 0
) (
    input  logic                           clk,
    input  logic                           clr_pc_n,
    input  logic                           ld_pc,
    input  logic [PC_W-1:0]                ld_val,
    input  logic                           call_pc,
    input  logic [PC_W-1:0]                call_tgt,
    input  logic                           ret_pc,
    input  logic                           br_pc,
    input  logic [PC_W-1:0]                br_off,
    input  logic                           inc_pc,
    output logic [PC_W-1:0]                pc_out,
    output logic                           pc_wrap,
    output logic [$clog2(STK_DEPTH+1)-1:0] stk_depth,
    output logic                           stk_ovf,
    output logic                           stk_unf,
    output logic                           cmd_err
);

    localparam int              DW     = $clog2(STK_DEPTH+1);
    localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);
    localparam logic [PC_W-1:0] RST_V  = PC_W'(RST_VAL);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            wrap_q, wrap_d;
    logic            err_q, err_d;

    // One extra bit catches unsigned carry-out; two extra bits for the branch
    // sum give a sign bit (negative result) and an overflow bit (>= 2^PC_W).
    logic [PC_W:0]   inc_sum;
    logic [PC_W+1:0] br_sum;

    assign inc_sum = {1'b0, pc_q} + {1'b0, STEP_V};
    assign br_sum  = {2'b00, pc_q} + {{2{br_off[PC_W-1]}}, br_off};

`ifdef PC_RET_STACK_EN
    localparam logic [DW-1:0] FULL = DW'(STK_DEPTH);
    localparam logic [DW-1:0] ONE  = DW'(1);

    logic [PC_W-1:0] stk_q [STK_DEPTH];
    logic [DW-1:0]   depth_q, depth_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            push, pop;
    logic [PC_W-1:0] top_val;
    logic            sel_call, sel_ret;

    // Priority slots for the stack commands: only the winning strobe acts.
    assign sel_call = !ld_pc && call_pc;
    assign sel_ret  = !ld_pc && !call_pc && ret_pc;

    // Top-of-stack read mux (entry depth-1); compare-based to avoid index width games.
    always_comb begin
        top_val = '0;
        for (int i = 0; i < STK_DEPTH; i++) begin
            if (DW'(i) == depth_q - ONE) top_val = stk_q[i];
        end
    end

    // Stack bookkeeping: push/pop decisions, depth and sticky error flags.
    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (sel_call) begin
            if (depth_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                push    = 1'b1;
                depth_d = depth_q + ONE;
            end
        end else if (sel_ret) begin
            if (depth_q == '0) begin
                unf_d = 1'b1;
            end else begin
                pop     = 1'b1;
                depth_d = depth_q - ONE;
            end
        end
    end

    // Stack storage: return address (pc+STEP) written at the current depth; no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STK_DEPTH; i++) begin
            if (push && DW'(i) == depth_q) stk_q[i] <= inc_sum[PC_W-1:0];
        end
    end

    // Stack status registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!clr_pc_n) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign stk_depth = depth_q;
    assign stk_ovf   = ovf_q;
    assign stk_unf   = unf_q;
`else
    assign stk_depth = '0;
    assign stk_ovf   = 1'b0;
    assign stk_unf   = 1'b0;
`endif

    // Next-PC selection by fixed priority: ld > call > ret > br > inc > hold.
    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
        err_d  = $countones({ld_pc, call_pc, ret_pc, br_pc, inc_pc}) > 1;
        if (ld_pc) begin
            pc_d = ld_val;
        end else if (call_pc) begin
            pc_d = call_tgt;
        end else if (ret_pc) begin
`ifdef PC_RET_STACK_EN
            if (pop) pc_d = top_val;
`endif
        end else if (br_pc) begin
            pc_d   = br_sum[PC_W-1:0];
            wrap_d = |br_sum[PC_W+1:PC_W];
        end else if (inc_pc) begin
            pc_d   = inc_sum[PC_W-1:0];
            wrap_d = inc_sum[PC_W];
        end
    end

    // PC and one-cycle pulse registers.
    always_ff @(posedge clk) begin
        if (!clr_pc_n) begin
            pc_q   <= RST_V;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign pc_out  = pc_q;
    assign pc_wrap = wrap_q;
    assign cmd_err = err_q;

endmodule

// File: tb/tb_pc_stack_seq.sv
// Self-checking bench for pc_stack_seq (PC_W=6, STEP=1, STK_DEPTH=4, RST_VAL=0).
// Adapts its expectations to whether PC_RET_STACK_EN is defined.
module tb_pc_stack_seq;

    localparam int PC_W = 6;
    localparam int DEP  = 4;
    localparam int MODV = 64;

    logic            clk = 1'b0;
    logic            clr_pc_n, ld_pc, call_pc, ret_pc, br_pc, inc_pc;
    logic [PC_W-1:0] ld_val, call_tgt, br_off;
    logic [PC_W-1:0] pc_out;
    logic            pc_wrap, stk_ovf, stk_unf, cmd_err;
    logic [2:0]      stk_depth;

    pc_stack_seq #(.PC_W(PC_W), .STEP(1), .STK_DEPTH(DEP), .RST_VAL(0)) dut (
        .clk(clk), .clr_pc_n(clr_pc_n), .ld_pc(ld_pc), .ld_val(ld_val),
        .call_pc(call_pc), .call_tgt(call_tgt), .ret_pc(ret_pc), .br_pc(br_pc),
        .br_off(br_off), .inc_pc(inc_pc), .pc_out(pc_out), .pc_wrap(pc_wrap),
        .stk_depth(stk_depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, ld, call, ret, br, inc;
        logic [5:0] lv, tgt, off;
    } in_t;

    typedef struct {
        in_t        i;
        logic [5:0] pc;
        logic       wrap, err;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference model state: PC as an integer, stack as a queue.
    int m_pc = 0;
    int m_stk[$];
    bit m_wrap, m_err, m_ovf, m_unf;

    function automatic in_t mk(bit r, bit ld, int lv, bit call, int tgt,
                               bit ret, bit br, int off, bit inc);
        in_t t;
        t.rst_n = r;  t.ld = ld;  t.lv = 6'(lv);
        t.call = call; t.tgt = 6'(tgt); t.ret = ret;
        t.br = br;    t.off = 6'(off); t.inc = inc;
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: one clock edge worth of behaviour, from the command rules.
    task automatic model(input in_t t);
        int s, so;
        if (!t.rst_n) begin
            m_pc = 0; m_stk.delete();
            m_wrap = 0; m_err = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        m_err  = (int'(t.ld) + int'(t.call) + int'(t.ret) + int'(t.br) + int'(t.inc)) > 1;
        m_wrap = 0;
        if (t.ld) m_pc = int'(t.lv);
        else if (t.call) begin
`ifdef PC_RET_STACK_EN
            if (m_stk.size() < DEP) m_stk.push_back((m_pc + 1) % MODV);
            else m_ovf = 1;
`endif
            m_pc = int'(t.tgt);
        end else if (t.ret) begin
`ifdef PC_RET_STACK_EN
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_unf = 1;
`endif
        end else if (t.br) begin
            so = t.off[5] ? int'(t.off) - MODV : int'(t.off);
            s  = m_pc + so;
            m_wrap = (s < 0) || (s >= MODV);
            m_pc = (s + MODV) % MODV;
        end else if (t.inc) begin
            s = m_pc + 1;
            m_wrap = s >= MODV;
            m_pc = s % MODV;
        end
    endtask

    // Drive one cycle, advance the model, sample 1 time unit after the edge.
    task automatic step(input in_t t);
        clr_pc_n = t.rst_n; ld_pc = t.ld; ld_val = t.lv; call_pc = t.call;
        call_tgt = t.tgt; ret_pc = t.ret; br_pc = t.br; br_off = t.off; inc_pc = t.inc;
        @(posedge clk);
        model(t);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"},    int'(pc_out),    m_pc);
        chk({tag, ".wrap"},  int'(pc_wrap),   int'(m_wrap));
        chk({tag, ".err"},   int'(cmd_err),   int'(m_err));
        chk({tag, ".depth"}, int'(stk_depth), m_stk.size());
        chk({tag, ".ovf"},   int'(stk_ovf),   int'(m_ovf));
        chk({tag, ".unf"},   int'(stk_unf),   int'(m_unf));
    endtask

    vec_t tbl[14];
    in_t  idle, r;

    initial begin
        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // inputs/expected: stack-independent vectors
        tbl[0]  = '{mk(0, 1, 'h2A, 0, 0, 0, 0, 0, 0), 6'h00, 0, 0};   // reset beats ld
        tbl[1]  = '{mk(1, 1, 'h3F, 0, 0, 0, 0, 0, 0), 6'h3F, 0, 0};
        tbl[2]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 1),    6'h00, 1, 0};   // inc wraps
        tbl[3]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 1),    6'h01, 0, 0};
        tbl[4]  = '{mk(1, 1, 5, 0, 0, 0, 0, 0, 0),    6'h05, 0, 0};
        tbl[5]  = '{mk(1, 0, 0, 0, 0, 0, 1, 'h3D, 0), 6'h02, 0, 0};   // 5-3
        tbl[6]  = '{mk(1, 1, 1, 0, 0, 0, 0, 0, 0),    6'h01, 0, 0};
        tbl[7]  = '{mk(1, 0, 0, 0, 0, 0, 1, 'h3D, 0), 6'h3E, 1, 0};   // 1-3 underflows
        tbl[8]  = '{idle,                              6'h3E, 0, 0};   // hold, pulse gone
        tbl[9]  = '{mk(1, 0, 0, 0, 0, 0, 1, 2, 0),    6'h00, 1, 0};   // 62+2 overflows
        tbl[10] = '{mk(1, 1, 7, 0, 0, 0, 1, 9, 1),    6'h07, 0, 1};   // ld wins, cmd_err
        tbl[11] = '{idle,                              6'h07, 0, 0};   // cmd_err one cycle
        tbl[12] = '{mk(1, 0, 0, 0, 0, 0, 1, 5, 1),    6'h0C, 0, 1};   // br beats inc
        tbl[13] = '{mk(0, 1, 'h20, 0, 0, 0, 0, 0, 0), 6'h00, 0, 0};

        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("rst.pc", int'(pc_out), 0);
        chk("rst.depth", int'(stk_depth), 0);
        chk("rst.flags", int'({pc_wrap, stk_ovf, stk_unf, cmd_err}), 0);

        for (int k = 0; k < 14; k++) begin
            step(tbl[k].i);
            chk($sformatf("vec%0d.pc", k),   int'(pc_out),  int'(tbl[k].pc));
            chk($sformatf("vec%0d.wrap", k), int'(pc_wrap), int'(tbl[k].wrap));
            chk($sformatf("vec%0d.err", k),  int'(cmd_err), int'(tbl[k].err));
        end

`ifdef PC_RET_STACK_EN
        // call / inc / ret round trip
        step(mk(1, 1, 10, 0, 0, 0, 0, 0, 0));
        step(mk(1, 0, 0, 1, 20, 0, 0, 0, 0));
        chk("call.pc", int'(pc_out), 20);
        chk("call.depth", int'(stk_depth), 1);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
        chk("call.inc", int'(pc_out), 21);
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
        chk("ret.pc", int'(pc_out), 11);
        chk("ret.depth", int'(stk_depth), 0);

        // five calls: fifth overflows; four rets LIFO; fifth ret underflows
        step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        step(mk(1, 0, 0, 1, 'h10, 0, 0, 0, 0));
        step(mk(1, 0, 0, 1, 'h20, 0, 0, 0, 0));
        step(mk(1, 0, 0, 1, 'h30, 0, 0, 0, 0));
        step(mk(1, 0, 0, 1, 'h08, 0, 0, 0, 0));
        chk("ovf.pre", int'(stk_ovf), 0);
        step(mk(1, 0, 0, 1, 'h18, 0, 0, 0, 0));
        chk("ovf.pc", int'(pc_out), 'h18);
        chk("ovf.depth", int'(stk_depth), 4);
        chk("ovf.flag", int'(stk_ovf), 1);
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0)); chk("lifo0", int'(pc_out), 'h31);
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0)); chk("lifo1", int'(pc_out), 'h21);
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0)); chk("lifo2", int'(pc_out), 'h11);
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0)); chk("lifo3", int'(pc_out), 'h01);
        chk("lifo.depth", int'(stk_depth), 0);
        chk("unf.pre", int'(stk_unf), 0);
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
        chk("unf.pc", int'(pc_out), 'h01);
        chk("unf.flag", int'(stk_unf), 1);
        step(idle);
        chk("sticky.ovf", int'(stk_ovf), 1);
        chk("sticky.unf", int'(stk_unf), 1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("clr.flags", int'({stk_ovf, stk_unf}), 0);
`else
        // without the stack, call is a load and ret is a hold
        step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        step(mk(1, 0, 0, 1, 9, 0, 0, 0, 0));
        chk("nostk.call.pc", int'(pc_out), 9);
        chk("nostk.call.depth", int'(stk_depth), 0);
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 1));
        chk("nostk.ret.pc", int'(pc_out), 9);
        chk("nostk.ret.err", int'(cmd_err), 1);
        chk("nostk.unf", int'(stk_unf), 0);
`endif

        // randomized traffic against the model
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int n = 0; n < 500; n++) begin
            r.rst_n = $urandom_range(0, 59) != 0;
            r.ld    = $urandom_range(0, 7) == 0;
            r.call  = $urandom_range(0, 3) == 0;
            r.ret   = $urandom_range(0, 3) == 0;
            r.br    = $urandom_range(0, 3) == 0;
            r.inc   = $urandom_range(0, 2) == 0;
            r.lv    = 6'($urandom);
            r.tgt   = 6'($urandom);
            r.off   = 6'($urandom);
            step(r);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
